ex_mul_sequencer: RTL and testbench

//  Multi-cycle shift-add multiply controller for the EX stage. Replaces the single-cycle A*B path.
//  - Accepts forwarded operands when EX decodes MUL (ALU_control 4'b0100).
//  - Stalls IF/ID/EX until the product is ready.
//  - Returns the low 32 bits of the product, plus a zero flag, to the EX/MEM result mux.

---
 rtl/ex_mul_sequencer.sv | 120 ++++++++++++
 tb/tb_ex_mul_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_sequencer.sv
// Multi-cycle shift-add multiplier controller for the EX stage.
// Optional MUL_EARLY_TERM_EN: leave RUN once the multiplier is exhausted.
module ex_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum;
  logic             capture;
  logic             last;

  assign capture = (state_q == IDLE) & start & ~flush;

  always_comb begin
    sum = acc_q;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) sum = sum + (mcand_q << i);
    end
  end

  always_comb begin
    last = (cnt_q == CW'(N - 1));
`ifdef MUL_EARLY_TERM_EN
    last = last | ((mplier_q >> STEP) == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = RUN;
      RUN: begin
        if (flush)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A squashed MUL must not freeze the front end.
  always_comb begin
    stall = capture | ((state_q == RUN) & ~flush);
    busy  = (state_q != IDLE);
    done  = (state_q == DONE) & ~flush;
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (capture) begin
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      acc_d    = sum;
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d    = cnt_q + CW'(1);
      if (last & ~flush) result_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign zero   = ~|result_q;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed and random bench for ex_mul_sequencer.
// Reference: plain truncated multiply and a latency formula.
module tb_ex_mul_sequencer;

  localparam int W = 32;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_res;

  ex_mul_sequencer #(.WIDTH(W), .STEP(S)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    int bits;
    int runs;
    bits = 0;
    runs = W / S;
`ifdef MUL_EARLY_TERM_EN
    for (int i = 0; i < W; i++)
      if (b[i]) bits = i + 1;
    runs = (bits + S - 1) / S;
    if (runs < 1) runs = 1;
`endif
    return runs + 1;
  endfunction

  // Issues one MUL from the next cycle; leaves start high.
  task automatic do_mul(input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] e;
    int           lat;
    e   = a * b;
    lat = exp_lat(b);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    #1;
    chk("stall_c0", stall, 1);
    chk("busy_c0", busy, 0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      op_a = $urandom;
      op_b = $urandom;
      if (c < lat) begin
        chk("stall_run", stall, 1);
        chk("done_early", done, 0);
      end else begin
        chk("done", done, 1);
        chk("result", result, e);
        chk("zero", zero, W'(e == 0));
        chk("stall_done", stall, 0);
      end
    end
    last_res = e;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    reset = 1'b0;

    do_mul(32'd7, 32'd6);
    do_mul(32'hFFFF_FFFF, 32'd2);
    do_mul(32'h0001_0000, 32'h0001_0000);
    start = 1'b0;

    // Squash mid-run: no done, result untouched.
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd9;
    for (int c = 1; c < 10; c++) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_done", done, 0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_idle", busy, 0);
    chk("flush_res", result, last_res);
    repeat (40) begin
      @(negedge clk);
      chk("flush_nodone", done, 0);
    end

    // start with flush in IDLE is not captured.
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("sf_stall", stall, 0);
    @(negedge clk);
    chk("sf_busy", busy, 0);
    start = 1'b0;
    flush = 1'b0;

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd123;
    op_b  = 32'd456;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("mrst_stall", stall, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_result", result, 0);
    chk("mrst_zero", zero, 1);
    reset = 1'b0;
    do_mul(32'd11, 32'd13);

    // Back-to-back: start stays high across DONE.
    do_mul(32'd3, 32'd4);
    do_mul(32'd5, 32'd5);
    start = 1'b0;

    do_mul(32'd5, 32'd1);
    do_mul(32'd5, 32'd0);
    start = 1'b0;

    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (k[0]) rb = rb >> $urandom_range(0, 31);
      do_mul(ra, rb);
      if (k[1]) start = 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
